// File: rtl/rpi_serial_link.sv
// ---------------------------------------------------------------------------
// rpi_serial_link
//
// Single-clock front end for the Raspberry Pi serial register link.
//
// The RPi drives three strobes (cclk, dclk, rclk) plus serial data and a
// latch enable, all asynchronous to the 50 MHz board clock. Every one of
// them is oversampled through the same synchroniser depth. This keeps a
// strobe and the data/le that go with it aligned in time. Rising edges of
// the synchronised strobes then drive plain clk-domain shift registers.
//
//   control channel (cclk) : shifts sdata MSB-first, latches on le=1
//                            into rcontrol with a one-cycle rcontrol_valid
//   data channel    (dclk) : identical, into rdata / rdata_valid
//   readback        (rclk) : le=1 loads {ti_control, ti_data} into a
//                            16-bit shadow, le=0 shifts it out MSB-first
//                            on rpi_sout (zeros fill in behind)
//
// A latch after any bit count other than 8 raises a sticky frame error,
// which stays set until err_clr. If a set and a clear land in the same
// cycle, the set wins.
//
// Ports
//   clk, rst                 board clock, asynchronous active-high reset
//   rpi_cclk/dclk/rclk       asynchronous strobes from the RPi
//   rpi_sdata, rpi_le        asynchronous serial data / latch enable
//   ti_control, ti_data      readback bytes (clk domain)
//   err_clr                  clears frame_err
//   rcontrol, rdata          latched bytes, with one-cycle *_valid pulses
//   frame_err[1:0]           [1] control channel, [0] data channel
//   rpi_sout                 readback serial out (registered)
//
// Parameters
//   SYNC_STAGES (>=2)        flops per input synchroniser
//   FILTER_LEN  (>=1)        high samples a strobe needs when filtered
//
// Build option
//   RPI_LINK_GLITCH_FILTER_EN  When defined, a strobe edge is accepted only
//                              once the strobe has been high for FILTER_LEN
//                              consecutive synchronised samples. Shorter
//                              pulses are dropped. The default build uses
//                              plain 0->1 edge detection.
// ---------------------------------------------------------------------------
module rpi_serial_link #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rpi_cclk,
    input  logic       rpi_dclk,
    input  logic       rpi_rclk,
    input  logic       rpi_sdata,
    input  logic       rpi_le,
    input  logic [7:0] ti_control,
    input  logic [7:0] ti_data,
    input  logic       err_clr,
    output logic [7:0] rcontrol,
    output logic [7:0] rdata,
    output logic       rcontrol_valid,
    output logic       rdata_valid,
    output logic [1:0] frame_err,
    output logic       rpi_sout
);

    // Strobe index also serves as channel index. Data is 0 and control is 1,
    // which lines up with the bit order of frame_err.
    localparam int CH_DATA   = 0;
    localparam int CH_CTRL   = 1;
    localparam int STRB_RCLK = 2;
    localparam int PIN_SDATA = 3;
    localparam int PIN_LE    = 4;

    // A configuration that cannot work (too few sync flops, or an empty
    // filter) blocks every strobe. A bad build then shows up as a dead
    // link instead of silently corrupting frames.
    localparam logic CFG_OK = (SYNC_STAGES >= 2) && (FILTER_LEN >= 1);

    // ------------------------------------------------------------------
    // Synchronisers: one vector, so all five pins see the same delay
    // ------------------------------------------------------------------
    logic [4:0] pins_s;
    logic [4:0] sync_d [SYNC_STAGES];
    logic [4:0] sync_q [SYNC_STAGES];
    logic [4:0] synced_s;
    logic [2:0] strb_s;
    logic       sdata_s;
    logic       le_s;
    logic [2:0] accept_s;

    // Next-state of the synchroniser chains and split of the final stage.
    always_comb begin
        pins_s = {rpi_le, rpi_sdata, rpi_rclk, rpi_cclk, rpi_dclk};
        sync_d[0] = pins_s;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        synced_s = sync_q[SYNC_STAGES-1];
        strb_s   = synced_s[2:0];
        sdata_s  = synced_s[PIN_SDATA];
        le_s     = synced_s[PIN_LE];
    end

    // Synchroniser flops, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 5'b0_0000;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge acceptance
    // ------------------------------------------------------------------
`ifdef RPI_LINK_GLITCH_FILTER_EN
    localparam int               RUN_W   = $clog2(FILTER_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILTER_LEN);
    localparam logic [RUN_W-1:0] RUN_HIT = RUN_W'(FILTER_LEN - 1);

    logic [RUN_W-1:0] run_d [3];
    logic [RUN_W-1:0] run_q [3];

    // Run counters count consecutive high samples and saturate. A low sample
    // restarts the count. The edge fires on the sample that completes
    // FILTER_LEN highs, and the counter saturating past that point keeps a
    // long pulse from firing twice. The reset value of zero counts as the
    // preceding low sample.
    always_comb begin
        for (int s = 0; s < 3; s++) begin
            if (strb_s[s] == 1'b0) begin
                run_d[s] = {RUN_W{1'b0}};
            end else if (run_q[s] != RUN_MAX) begin
                run_d[s] = run_q[s] + RUN_W'(1);
            end else begin
                run_d[s] = run_q[s];
            end
            if (strb_s[s] && (run_q[s] == RUN_HIT)) begin
                accept_s[s] = CFG_OK;
            end else begin
                accept_s[s] = 1'b0;
            end
        end
    end

    // Run counter flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 3; s++) begin
                run_q[s] <= {RUN_W{1'b0}};
            end
        end else begin
            for (int s = 0; s < 3; s++) begin
                run_q[s] <= run_d[s];
            end
        end
    end
`else
    logic [2:0] prev_d;
    logic [2:0] prev_q;

    // Plain rising-edge detect on the synchronised strobes.
    always_comb begin
        prev_d   = strb_s;
        accept_s = strb_s & ~prev_q & {3{CFG_OK}};
    end

    // Edge-history flops. Reset to 0, so a strobe already high at reset
    // release is taken as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 3'b000;
        end else begin
            prev_q <= prev_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Control / data channels
    // ------------------------------------------------------------------
    logic [7:0] sr_d    [2];
    logic [7:0] sr_q    [2];
    logic [3:0] cnt_d   [2];
    logic [3:0] cnt_q   [2];
    logic [7:0] out_d   [2];
    logic [7:0] out_q   [2];
    logic [1:0] valid_d;
    logic [1:0] valid_q;
    logic [1:0] err_set_s;
    logic [1:0] err_d;
    logic [1:0] err_q;

    // Shift, count and latch for both channels. Both channels read the same
    // sdata/le sample, so simultaneous edges behave identically. A latch
    // leaves the shift register alone and only clears the bit count.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            sr_d[ch]      = sr_q[ch];
            cnt_d[ch]     = cnt_q[ch];
            out_d[ch]     = out_q[ch];
            valid_d[ch]   = 1'b0;
            err_set_s[ch] = 1'b0;
            if (accept_s[ch]) begin
                if (le_s) begin
                    out_d[ch]     = sr_q[ch];
                    valid_d[ch]   = 1'b1;
                    err_set_s[ch] = (cnt_q[ch] != 4'd8);
                    cnt_d[ch]     = 4'd0;
                end else begin
                    sr_d[ch] = {sr_q[ch][6:0], sdata_s};
                    // The count saturates, so a long frame can never wrap
                    // around to look like a clean 8.
                    if (cnt_q[ch] != 4'd15) begin
                        cnt_d[ch] = cnt_q[ch] + 4'd1;
                    end else begin
                        cnt_d[ch] = cnt_q[ch];
                    end
                end
            end else begin
                sr_d[ch]  = sr_q[ch];
                cnt_d[ch] = cnt_q[ch];
            end
        end
    end

    // Sticky frame errors: a clear is applied first, then any new set is
    // ORed on top, so a set in the same cycle survives the clear.
    always_comb begin
        if (err_clr) begin
            err_d = 2'b00;
        end else begin
            err_d = err_q;
        end
        err_d = err_d | err_set_s;
    end

    // ------------------------------------------------------------------
    // Readback shadow
    // ------------------------------------------------------------------
    logic [15:0] shadow_d;
    logic [15:0] shadow_q;
    logic        sout_d;
    logic        sout_q;

    // Load or shift the shadow. The pin is registered from the next-state
    // MSB, so rpi_sout changes on the same edge as the channel valids.
    always_comb begin
        if (accept_s[STRB_RCLK]) begin
            if (le_s) begin
                shadow_d = {ti_control, ti_data};
            end else begin
                shadow_d = {shadow_q[14:0], 1'b0};
            end
        end else begin
            shadow_d = shadow_q;
        end
        sout_d = shadow_d[15];
    end

    // Channel, error and readback flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                sr_q[ch]  <= 8'h00;
                cnt_q[ch] <= 4'd0;
                out_q[ch] <= 8'h00;
            end
            valid_q  <= 2'b00;
            err_q    <= 2'b00;
            shadow_q <= 16'h0000;
            sout_q   <= 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                sr_q[ch]  <= sr_d[ch];
                cnt_q[ch] <= cnt_d[ch];
                out_q[ch] <= out_d[ch];
            end
            valid_q  <= valid_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
            sout_q   <= sout_d;
        end
    end

    assign rcontrol       = out_q[CH_CTRL];
    assign rdata          = out_q[CH_DATA];
    assign rcontrol_valid = valid_q[CH_CTRL];
    assign rdata_valid    = valid_q[CH_DATA];
    assign frame_err      = err_q;
    assign rpi_sout       = sout_q;

endmodule

// File: doc/rpi_serial_link.md
# rpi_serial_link

Clock-domain front end for the Raspberry Pi serial register link. It oversamples the RPi strobes (`rpi_cclk`, `rpi_dclk`, `rpi_rclk`, `rpi_le`) and data (`rpi_sdata`) on the 50 MHz board clock, shifts in the RPi→TI control and data bytes, and presents them as clean, clk-synchronous registers with one-cycle valid pulses. In the other direction it serialises the TI-written control and data bytes back to the RPi on a single pin. It sits between the RPi header pins and the TI bus decode/register logic, replacing strobe-clocked shift registers with a single-clock design.

## Interface
- `SYNC_STAGES`, 2: flops in each input synchroniser; must be ≥2.
- `FILTER_LEN`, 3: consecutive high samples required to accept a strobe edge. Used only with the glitch filter.
- `clk`  in  1  50 MHz board clock. All state is on its rising edge.
- `rst`  in  1  Reset, asynchronous, active-high. Clears all state.
- `rpi_cclk`  in  1  Control-channel strobe (async).
- `rpi_dclk`  in  1  Data-channel strobe (async).
- `rpi_rclk`  in  1  Readback strobe (async).
- `rpi_sdata`  in  1  Serial data in (async), MSB first.
- `rpi_le`  in  1  Latch enable / readback load (async).
- `ti_control`  in  8  TI-written control byte (clk domain).
- `ti_data`  in  8  TI-written data byte (clk domain).
- `err_clr`  in  1  Clears the sticky error flags.
- `rcontrol`  out  8  Latched RPi control byte.
- `rdata`  out  8  Latched RPi data byte.
- `rcontrol_valid`  out  1  One-cycle pulse when `rcontrol` updates.
- `rdata_valid`  out  1  One-cycle pulse when `rdata` updates.
- `frame_err`  out  2  Sticky short/long-frame flags: [1] control channel, [0] data channel.
- `rpi_sout`  out  1  Readback serial out, MSB first.

## Operation
- **Synchronisers.** All five async inputs pass through identical `SYNC_STAGES` flop chains, so strobe, `sdata` and `le` stay aligned.
- **Edge detection.**
  - A strobe edge is accepted when the synchronised strobe is 1 and its previous synchronised value was 0.
  - The `sdata` and `le` values used with an edge are the synchronised values in the same cycle.
- **Control and data channels.** The two channels are independent and identical. On an accepted edge:
  - **`le` = 0:** shift register ← {sr[6:0], sdata}. The bit counter increments and saturates at 15.
  - **`le` = 1:**
    - Output register ← sr, and the valid output pulses high for exactly one cycle.
    - If the bit counter ≠ 8, the channel's `frame_err` bit is set. The latch still occurs.
    - The bit counter clears to 0.
    - The shift register is not altered.
- **Simultaneous edges.** `cclk` and `dclk` edges accepted in the same cycle both act on the same `sdata`/`le` value.
- **Readback channel.** On an accepted `rclk` edge:
  - **`le` = 1:** the 16-bit shadow register ← {`ti_control`, `ti_data`} sampled that cycle.
  - **`le` = 0:** shadow ← {shadow[14:0], 0}.
  - `rpi_sout` = shadow[15], registered. Bits beyond 16 read 0.
- **Error flags.**
  - Sticky until `err_clr`.
  - If a set and `err_clr` occur in the same cycle, the set wins.
- **Reset values.** Asynchronous `rst` clears every synchroniser, edge history, shift register, counter and output:
  - `rcontrol` = `rdata` = 0x00
  - valids = 0
  - `frame_err` = 2'b00
  - `rpi_sout` = 0
- **Reset mid-frame.** A partial frame is discarded. The next frame needs a full 8 shifts to latch without error.

## Timing
- **Latency.** A strobe first sampled high at clk edge k is accepted, and `rcontrol`/`rdata`/`rpi_sout` update together with the valid pulse, at edge k + `SYNC_STAGES`: edge k+2 by default.
- **Setup/hold at the pins.** `rpi_sdata` and `rpi_le` must be stable from 1 clk period before the strobe rises until `SYNC_STAGES`+1 periods after it rises.
- **Minimum strobe widths.**
  - High: ≥ `SYNC_STAGES`+1 clk periods (60 ns at 50 MHz). Add `FILTER_LEN`−1 periods with the filter.
  - Low: ≥ `SYNC_STAGES`+1 clk periods (60 ns at 50 MHz).
- **Throughput.** At most one accepted edge per strobe per cycle. A strobe period ≥ 2×(`SYNC_STAGES`+1) cycles is guaranteed lossless.
- **Valid pulses.** Never wider than one cycle. Two consecutive latches produce two separated pulses.

## Configuration
- `RPI_LINK_GLITCH_FILTER_EN`
  - **Defined:** each synchronised strobe feeds a saturating run counter. An edge is accepted only on the cycle the strobe has been high for `FILTER_LEN` consecutive samples following at least one low sample. `sdata`/`le` are taken from that cycle. Latency becomes `SYNC_STAGES`+`FILTER_LEN`−1. Pulses shorter than `FILTER_LEN` cycles are ignored entirely.
  - **Undefined:** every 0→1 transition of a synchronised strobe is accepted, as described under Operation. The run counters are not built.

## Test plan
- **Control frame.** Shift 0xA5 MSB-first on `cclk` with `le`=0, then one `cclk` with `le`=1 → `rcontrol`=0xA5, a single `rcontrol_valid` pulse 2 cycles after the strobe, `frame_err`=00, `rdata` unchanged at 0x00.
- **Simultaneous channels.** Pulse `cclk` and `dclk` together with 0x3C, then latch both → `rcontrol`=`rdata`=0x3C, both valids pulse in the same cycle.
- **Short frame.** 5 shifts then latch on `dclk` → `rdata` = sr value 0x15 for bits 10101, `frame_err`=01. Assert `err_clr` → 00. Assert `err_clr` coincident with another short latch → flag stays 1.
- **Readback.** `ti_control`=0x12, `ti_data`=0x34, `rclk` with `le`=1, then 16 `rclk` with `le`=0 → `rpi_sout` sequence 0x1234 MSB-first, then 0s.
- **Reset mid-frame.** 4 shifts, assert `rst` asynchronously mid-cycle → all outputs 0 immediately. A following full 8-bit frame 0xFF latches with no error.
- **Glitch filter (macro defined).** A 1-cycle `cclk` high pulse → no shift, no count. A 3-cycle pulse → accepted, latency 4 cycles.
